// File: rtl/dequantization.sv
// Dequantizer: multiplies each element of an 8x8 coefficient block by its quantization-matrix
// entry, one element per clock. Define DEQUANT_SAT_EN to saturate products instead of wrapping.
module dequantization #(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     Clock,
  input  logic                     reset,
  input  logic                     Enable,
  input  logic [N*N*DATA_W-1:0]    A,
  input  logic [N*N*DATA_W-1:0]    B,
  output logic [N*N*DATA_W-1:0]    C,
  output logic                     done
);

  localparam int unsigned Elems = N * N;
  localparam int unsigned IdxW  = $clog2(Elems);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Elems - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul,
    StPack,
    StHold
  } state_e;

  state_e                    state;
  logic [IdxW-1:0]           index;
  logic signed [DATA_W-1:0]  a_mat [Elems];
  logic signed [DATA_W-1:0]  b_mat [Elems];
  logic signed [DATA_W-1:0]  work  [Elems];

  logic signed [DATA_W-1:0]  a_cur;
  logic signed [DATA_W-1:0]  b_cur;
  logic signed [DATA_W-1:0]  product_red;

  assign a_cur = a_mat[index];
  assign b_cur = b_mat[index];

`ifdef DEQUANT_SAT_EN
  localparam int unsigned ProdW = 2 * DATA_W;

  logic signed [ProdW-1:0] product;
  logic        [DATA_W:0]  upper;

  // The product fits in DATA_W bits only if all bits above the result sign agree with it.
  always_comb begin
    product = $signed({{DATA_W{a_cur[DATA_W-1]}}, a_cur})
            * $signed({{DATA_W{b_cur[DATA_W-1]}}, b_cur});
    upper   = product[ProdW-1:DATA_W-1];
    if (!upper[DATA_W] && (|upper)) begin
      product_red = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (upper[DATA_W] && !(&upper)) begin
      product_red = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      product_red = product[DATA_W-1:0];
    end
  end
`else
  // The low DATA_W bits of a signed product are the two's-complement wrapped result.
  always_comb begin
    product_red = a_cur * b_cur;
  end
`endif

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      index <= '0;
      C     <= '0;
      done  <= 1'b0;
      for (int k = 0; k < int'(Elems); k++) begin
        a_mat[k] <= '0;
        b_mat[k] <= '0;
        work[k]  <= '0;
      end
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (Enable) begin
            state <= StLoad;
          end
        end

        StLoad: begin
          if (!Enable) begin
            state <= StIdle;
          end else begin
            for (int k = 0; k < int'(Elems); k++) begin
              a_mat[k] <= A[k*DATA_W +: DATA_W];
              b_mat[k] <= B[k*DATA_W +: DATA_W];
              work[k]  <= '0;
            end
            index <= '0;
            state <= StMul;
          end
        end

        StMul: begin
          if (!Enable) begin
            state <= StIdle;
          end else begin
            work[index] <= product_red;
            if (index == LastIdx) begin
              state <= StPack;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        // Whole block is published at once so C never shows a partial result.
        StPack: begin
          for (int k = 0; k < int'(Elems); k++) begin
            C[k*DATA_W +: DATA_W] <= work[k];
          end
          done  <= 1'b1;
          state <= StHold;
        end

        StHold: begin
          if (!Enable) begin
            done  <= 1'b0;
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dequantization.sv
// Randomized self-checking bench for dequantization against an integer reference model.
module tb_dequantization;

  logic          Clock;
  logic          reset;
  logic          Enable;
  logic [1023:0] A;
  logic [1023:0] B;
  logic [1023:0] C;
  logic          done;

  int checks;
  int failures;

  int          ma [64];
  int          mb [64];
  logic [15:0] exp_c [64];

  dequantization dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .A      (A),
    .B      (B),
    .C      (C),
    .done   (done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] ref_elem(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
`ifdef DEQUANT_SAT_EN
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
`endif
    return 16'(p);
  endfunction

  task automatic drive_mats();
    for (int k = 0; k < 64; k++) begin
      A[k*16 +: 16] = 16'(ma[k]);
      B[k*16 +: 16] = 16'(mb[k]);
    end
  endtask

  task automatic check_c(input string tag);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("%s[%0d]", tag, k), 32'(C[k*16 +: 16]), 32'(exp_c[k]));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Starts from IDLE just after an edge; done must appear exactly on edge 66.
  task automatic full_run(input string tag);
    drive_mats();
    Enable = 1'b1;
    for (int e = 0; e <= 66; e++) begin
      @(posedge Clock);
      #1;
      if (e == 65) chk({tag, "_done_pre"}, 32'(done), 32'd0);
      if (e == 2) begin
        for (int k = 0; k < 64; k++) begin
          A[k*16 +: 16] = 16'($urandom);
          B[k*16 +: 16] = 16'($urandom);
        end
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    for (int k = 0; k < 64; k++) exp_c[k] = ref_elem(ma[k], mb[k]);
    check_c(tag);
  endtask

  task automatic release_run(input string tag);
    Enable = 1'b0;
    step(1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  task automatic rand_mats(input int mode);
    for (int k = 0; k < 64; k++) begin
      if (mode == 0) begin
        ma[k] = $urandom_range(0, 255) - 128;
        mb[k] = $urandom_range(0, 255);
      end else begin
        ma[k] = int'($signed(16'($urandom)));
        mb[k] = int'($signed(16'($urandom)));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Enable   = 1'b0;
    A        = '0;
    B        = '0;
    for (int k = 0; k < 64; k++) exp_c[k] = '0;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_done", 32'(done), 32'd0);
    check_c("rst_c");

    // Basic
    for (int k = 0; k < 64; k++) begin ma[k] = 3; mb[k] = 16; end
    full_run("basic");
    chk("basic_c0", 32'(C[15:0]), 32'd48);
    release_run("basic");

    // Signs and ordering
    for (int k = 0; k < 64; k++) begin ma[k] = k - 32; mb[k] = 2; end
    full_run("sign");
    chk("sign_first", 32'(C[15:0]), 32'hFFC0);
    chk("sign_last", 32'(C[1023:1008]), 32'd62);
    release_run("sign");

    // Reset mid-MUL clears C and done immediately
    rand_mats(0);
    drive_mats();
    Enable = 1'b1;
    step(20);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) exp_c[k] = '0;
    chk("rstmid_done", 32'(done), 32'd0);
    check_c("rstmid_c");
    Enable = 1'b0;
    step(1);
    reset = 1'b0;
    step(80);
    chk("rstidle_done", 32'(done), 32'd0);
    check_c("rstidle_c");

    // Overflow, positive then negative
    rand_mats(0);
    ma[0] = 1000; mb[0] = 100;
    full_run("ovfp");
`ifdef DEQUANT_SAT_EN
    chk("ovfp_c00", 32'(C[15:0]), 32'h7FFF);
`else
    chk("ovfp_c00", 32'(C[15:0]), 32'h86A0);
`endif
    release_run("ovfp");
    ma[0] = -1000;
    full_run("ovfn");
`ifdef DEQUANT_SAT_EN
    chk("ovfn_c00", 32'(C[15:0]), 32'h8000);
`else
    chk("ovfn_c00", 32'(C[15:0]), 32'h7960);
`endif
    release_run("ovfn");

    // Abort at edge 30 keeps the previous C
    rand_mats(1);
    drive_mats();
    Enable = 1'b1;
    step(30);
    Enable = 1'b0;
    step(1);
    chk("abort_done", 32'(done), 32'd0);
    check_c("abort_c");
    step(5);
    chk("abort_idle_done", 32'(done), 32'd0);
    full_run("rerun");

    // Hold: result stays put with Enable high and A changing
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (c == 40) begin
        for (int k = 0; k < 64; k++) A[k*16 +: 16] = 16'($urandom);
      end
      if (c % 20 == 19) chk($sformatf("hold_done_%0d", c), 32'(done), 32'd1);
    end
    check_c("hold_c");
    release_run("hold");

    // Random full-range runs
    for (int r = 0; r < 4; r++) begin
      rand_mats(r % 2 == 0 ? 1 : 0);
      full_run($sformatf("rand%0d", r));
      release_run($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
